transmisor_ps2: RTL and testbench

Host-to-device PS/2 transmitter for the keyboard interface: sends one command byte (e.g. 0xED LED set, 0xFF reset) from the FPGA to the keyboard over the shared open-drain PS2C/PS2D lines. It runs the full request-to-send, device-clocked bit shifting, odd-parity, stop and acknowledge sequence. It sits beside the PS/2 byte receiver; while `tx_idle` is low, the receiver's scan results are ignored.

---
 rtl/transmisor_ps2.sv | 106 ++++++++++
 tb/tb_transmisor_ps2.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/transmisor_ps2.sv
// transmisor_ps2: PS/2 host-to-device byte sender (clk_nexys/reset in; wr_ps2+din start; ps2c/ps2d open-drain; tx_idle, tx_done_tick, tx_error out)
module transmisor_ps2 #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_nexys,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_error
);
  localparam int CW = $clog2(((TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, RTS, REQ, START, DATA, ACK, WAIT_REL} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [8:0] sh_q, sh_d;
  logic ack_q, ack_d;
  logic [7:0] filt_q, filt_d;
  logic fclk_q, fclk_d;
  logic [1:0] dsync_q, dsync_d;
  logic fall_edge, ps2d_s, busy, timeout, released, c_en, d_en;
  assign filt_d = {ps2c, filt_q[7:1]};
  assign fclk_d = &filt_d ? 1'b1 : ~|filt_d ? 1'b0 : fclk_q;
  assign fall_edge = fclk_q & ~fclk_d;
  assign dsync_d = {ps2d, dsync_q[1]};
  assign ps2d_s = dsync_q[0];
  assign busy = state_q inside {START, DATA, ACK, WAIT_REL};
  assign timeout = busy && cnt_q == CW'(TIMEOUT_CYCLES);
  assign released = fclk_q & ps2d_s;
  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ack_q   <= 1'b0;
      filt_q  <= '1;
      fclk_q  <= 1'b1;
      dsync_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ack_q   <= ack_d;
      filt_q  <= filt_d;
      fclk_q  <= fclk_d;
      dsync_q <= dsync_d;
    end
  end
  // sh_q[0] is the bit currently presented on ps2d; the stop bit is just a release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_ps2) begin
          state_d = RTS;
          sh_d    = {~^din, din};
        end
      end
      RTS: state_d = cnt_q == CW'(INHIBIT_CYCLES - 2) ? REQ : RTS;
      REQ: begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (fall_edge) begin
        state_d = DATA;
        bit_d   = 4'd1;
      end
      DATA: if (fall_edge) begin
        if (bit_q == 4'd9) state_d = ACK;
        else begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 4'd1;
        end
      end
      ACK: if (fall_edge) begin
        state_d = WAIT_REL;
        ack_d   = ~ps2d_s;
      end
      WAIT_REL: state_d = released ? IDLE : WAIT_REL;
      default: state_d = IDLE;
    endcase
    if (busy && fall_edge) cnt_d = '0;
    if (timeout) state_d = IDLE;
  end
  always_comb begin
    c_en         = (state_q == RTS || state_q == REQ) && !timeout;
    d_en         = (state_q == REQ || state_q == START || (state_q == DATA && !sh_q[0])) && !timeout;
    tx_idle      = state_q == IDLE;
    tx_done_tick = state_q == WAIT_REL && released && ack_q && !timeout;
    tx_error     = timeout || (state_q == WAIT_REL && released && !ack_q);
  end
  assign ps2c = c_en ? 1'b0 : 1'bz;
  assign ps2d = d_en ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_transmisor_ps2.sv
// tb_transmisor_ps2: randomized device-model bench for transmisor_ps2
module tb_transmisor_ps2;
  localparam int INH = 100;
  localparam int TMO = 500;
  localparam int HALF = 20;
  logic clk_nexys = 1'b0;
  logic reset = 1'b0;
  logic wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic dev_c = 1'b0;
  logic dev_d_low = 1'b0;
  logic tx_idle, tx_done_tick, tx_error;
  wire ps2c, ps2d;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int c1 = 0;
  transmisor_ps2 #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_nexys(clk_nexys), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c), .ps2d(ps2d),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_error(tx_error)
  );
  assign ps2c = dev_c ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);
  initial forever #5 clk_nexys = ~clk_nexys;
  always @(posedge clk_nexys) cyc <= cyc + 1;
  always @(negedge clk_nexys) begin
    if (tx_done_tick) n_done <= n_done + 1;
    if (tx_error) n_err <= n_err + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_tx(input logic [7:0] b);
    int lowc;
    @(negedge clk_nexys);
    din = b;
    wr_ps2 = 1'b1;
    @(negedge clk_nexys);
    wr_ps2 = 1'b0;
    c1 = cyc;
    check("busy", tx_idle, 0);
    lowc = 0;
    for (int k = 1; k <= INH + 1; k++) begin
      if (k > 1) @(negedge clk_nexys);
      if (k <= INH && ps2c === 1'b0) lowc++;
      if (k == INH - 1) check("rts_data", ps2d, 1);
      if (k == INH) check("req_data", ps2d, 0);
      if (k == INH + 1) begin
        check("start_clk", ps2c, 1);
        check("start_data", ps2d, 0);
      end
    end
    check("rts_low", lowc, INH);
  endtask
  task automatic device_frame(input logic [7:0] b, input bit ack, input int glitch_at, input int wr_at, input int rst_at);
    logic [9:0] bits;
    int d0, e0, w;
    bit aborted;
    d0 = n_done;
    e0 = n_err;
    aborted = 0;
    bits = '0;
    start_tx(b);
    repeat (HALF) @(negedge clk_nexys);
    for (int i = 1; i <= 11 && !aborted; i++) begin
      dev_c = 1'b1;
      if (i == rst_at) begin
        reset = 1'b0;
        #1;
        check("rst_ps2d", ps2d, 1);
        check("rst_idle", tx_idle, 1);
        repeat (3) @(negedge clk_nexys);
        dev_c = 1'b0;
        #1;
        check("rst_ps2c", ps2c, 1);
        reset = 1'b1;
        aborted = 1;
      end else begin
        repeat (HALF) @(negedge clk_nexys);
        if (i <= 10) bits[i-1] = ps2d;
        dev_c = 1'b0;
        if (i == 11) dev_d_low = 1'b0;
        if (i == wr_at) begin
          din = 8'h00;
          wr_ps2 = 1'b1;
          @(negedge clk_nexys);
          wr_ps2 = 1'b0;
        end
        if (i == glitch_at) begin
          repeat (8) @(negedge clk_nexys);
          dev_c = 1'b1;
          repeat (5) @(negedge clk_nexys);
          dev_c = 1'b0;
        end
        repeat (HALF) @(negedge clk_nexys);
        if (i == 10) dev_d_low = ack;
      end
    end
    if (aborted) begin
      repeat (20) @(negedge clk_nexys);
      check("rst_done", n_done - d0, 0);
      check("rst_err", n_err - e0, 0);
      check("rst_idle_after", tx_idle, 1);
    end else begin
      w = 0;
      while (!tx_idle && w < 100) begin
        @(negedge clk_nexys);
        w++;
      end
      check("idle_wait", tx_idle, 1);
      repeat (5) @(negedge clk_nexys);
      check("data", bits[7:0], b);
      check("parity", bits[8], ($countones(b) % 2 == 0) ? 1 : 0);
      check("stop", bits[9], 1);
      check("done_cnt", n_done - d0, ack ? 1 : 0);
      check("err_cnt", n_err - e0, ack ? 0 : 1);
      check("end_clk", ps2c, 1);
      check("end_data", ps2d, 1);
    end
  endtask
  task automatic timeout_frame();
    int e0, w;
    e0 = n_err;
    start_tx(8'hA5);
    w = 0;
    while (tx_error !== 1'b1 && w < 1000) begin
      @(negedge clk_nexys);
      w++;
    end
    check("tmo_cycle", cyc - c1, INH + TMO);
    @(negedge clk_nexys);
    check("tmo_idle", tx_idle, 1);
    check("tmo_clk", ps2c, 1);
    check("tmo_data", ps2d, 1);
    repeat (5) @(negedge clk_nexys);
    check("tmo_err_cnt", n_err - e0, 1);
  endtask
  initial begin
    repeat (4) @(negedge clk_nexys);
    check("reset_idle", tx_idle, 1);
    check("reset_done", tx_done_tick, 0);
    check("reset_err", tx_error, 0);
    check("reset_clk", ps2c, 1);
    check("reset_data", ps2d, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk_nexys);
    device_frame(8'hED, 1, 0, 0, 0);
    device_frame(8'h07, 0, 0, 0, 0);
    timeout_frame();
    device_frame(8'hFF, 1, 0, 4, 0);
    device_frame(8'h3C, 1, 5, 0, 0);
    device_frame(8'h00, 1, 0, 0, 5);
    device_frame(8'hFF, 1, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      bit a;
      int g;
      b = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      g = $urandom_range(0, 1) ? $urandom_range(2, 10) : 0;
      device_frame(b, a, g, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
